// File: rtl/pc_fetch_stage_if.sv
// Instruction-memory fetch bus: one request strobe, one response strobe.
// The fetch stage is the master; the memory is the slave.
interface pc_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// RV32I IF stage: PC register, single-outstanding imem fetch, IF/ID register.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_stall counters.
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] npc,
    input  logic        redirect,
    input  logic        stall,
    output logic [31:0] pc_plus4,
    pc_fetch_stage_if.master imem,
    output logic [31:0] pc_ID,
    output logic [31:0] inst_ID,
    output logic        valid_ID
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      r_state;
    state_t      w_state_nx;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nx;
    logic [31:0] r_hold_pc;
    logic [31:0] r_hold_inst;
    logic [31:0] r_pc_id;
    logic [31:0] r_inst_id;
    logic        r_valid_id;
    logic        w_load;
    logic        w_kill;
    logic        w_hold_cap;
    logic [31:0] w_ld_pc;
    logic [31:0] w_ld_inst;
    logic        w_rvalid;

    assign w_rvalid       = imem.imem_rvalid;
    assign pc_plus4       = r_pc + 32'd4;
    assign imem.imem_addr = r_pc;
    assign imem.imem_req  = rst_n & (r_state == S_REQ);
    assign pc_ID          = r_pc_id;
    assign inst_ID        = r_inst_id;
    assign valid_ID       = r_valid_id;

    // Redirect wins over stall and over a same-cycle response.
    always_comb begin
        w_state_nx = r_state;
        w_pc_nx    = r_pc;
        w_load     = 1'b0;
        w_kill     = 1'b0;
        w_hold_cap = 1'b0;
        w_ld_pc    = r_pc;
        w_ld_inst  = imem.imem_rdata;
        unique case (r_state)
            S_REQ: begin
                if (redirect) begin
                    w_pc_nx    = npc;
                    w_kill     = 1'b1;
                    w_state_nx = S_DROP;
                end else begin
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_pc_nx    = npc;
                    w_kill     = 1'b1;
                    w_state_nx = w_rvalid ? S_REQ : S_DROP;
                end else if (w_rvalid) begin
                    if (stall) begin
                        w_hold_cap = 1'b1;
                        w_state_nx = S_HOLD;
                    end else begin
                        w_load     = 1'b1;
                        w_pc_nx    = npc;
                        w_state_nx = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    w_pc_nx    = npc;
                    w_kill     = 1'b1;
                    w_state_nx = S_REQ;
                end else if (!stall) begin
                    w_load     = 1'b1;
                    w_ld_pc    = r_hold_pc;
                    w_ld_inst  = r_hold_inst;
                    w_pc_nx    = npc;
                    w_state_nx = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    w_pc_nx = npc;
                    w_kill  = 1'b1;
                end
                if (w_rvalid) begin
                    w_state_nx = S_REQ;
                end
            end
            default: w_state_nx = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nx;
            r_pc    <= w_pc_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_pc   <= 32'd0;
            r_hold_inst <= NOP_INST;
        end else if (w_hold_cap) begin
            r_hold_pc   <= r_pc;
            r_hold_inst <= imem.imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_id    <= 32'd0;
            r_inst_id  <= NOP_INST;
            r_valid_id <= 1'b0;
        end else if (w_kill) begin
            r_inst_id  <= NOP_INST;
            r_valid_id <= 1'b0;
        end else if (w_load) begin
            r_pc_id    <= w_ld_pc;
            r_inst_id  <= w_ld_inst;
            r_valid_id <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetched;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= 32'd0;
            r_perf_stall   <= 32'd0;
        end else begin
            if (w_load) begin
                r_perf_fetched <= r_perf_fetched + 32'd1;
            end
            if (r_state != S_REQ) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
